// File: rtl/ili9341_init_seq.sv
// ili9341_init_seq
// Power-on sequencer for an ILI9341 panel. On start it pulses the panel
// hardware reset, waits out the reset recovery time, then walks a fixed
// 16-entry command ROM. CMD/DAT bytes go to the SPI byte serializer over a
// valid/ready handshake; DLY entries insert N * DELAY_UNIT_CYC idle cycles.
// When the END entry is reached, done is raised so the pixel stage can take
// over the bus.
//
// Ports:
//   sysclk    in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle run request, honoured in IDLE or DONE
//   busy      out  high while the sequence is running
//   done      out  sticky completion flag, cleared by the next accepted start
//   tft_rst   out  panel hardware reset, active low
//   tx_valid  out  byte available to the serializer
//   tx_ready  in   serializer accepts the byte
//   tx_data   out  byte to send
//   tx_dc     out  0 = command, 1 = data
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start after reset
// RST_LOW  | tft_rst held low for RST_LOW_CYC cycles
// RST_WAIT | tft_rst released, waiting RST_WAIT_CYC cycles
// FETCH    | decode ROM[index]
// SEND     | byte presented, waiting for tx_ready
// DELAY    | N units of DELAY_UNIT_CYC cycles each
// DONE     | sequence complete, done held high

module ili9341_init_seq #(
   parameter int RST_LOW_CYC    = 120,
   parameter int RST_WAIT_CYC   = 60000,
   parameter int DELAY_UNIT_CYC = 12000
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       tft_rst,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_dc
);

   // One counter serves both reset phases, so it is sized for the longer one.
   localparam int RC_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
   localparam int CNT_W  = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
   localparam int UNIT_W = (DELAY_UNIT_CYC > 1) ? $clog2(DELAY_UNIT_CYC) : 1;

   localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
   localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(DELAY_UNIT_CYC - 1);

   localparam logic [1:0] T_CMD = 2'd0;
   localparam logic [1:0] T_DAT = 2'd1;
   localparam logic [1:0] T_DLY = 2'd2;
   localparam logic [1:0] T_END = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_WAIT,
      S_FETCH,
      S_SEND,
      S_DELAY,
      S_DONE
   } state_t;

   state_t            state;
   logic [3:0]        idx;
   logic [CNT_W-1:0]  cnt;
   logic [UNIT_W-1:0] unit_cnt;
   logic [7:0]        unit_num;
   logic [7:0]        unit_last;
   logic [9:0]        rom_entry;
   logic [1:0]        rom_type;
   logic [7:0]        rom_byte;

   always_comb begin
      rom_entry = {T_END, 8'h00};
      case (idx)
         4'd0:    rom_entry = {T_CMD, 8'h01};
         4'd1:    rom_entry = {T_DLY, 8'd5};
         4'd2:    rom_entry = {T_CMD, 8'h11};
         4'd3:    rom_entry = {T_DLY, 8'd120};
         4'd4:    rom_entry = {T_CMD, 8'h3A};
         4'd5:    rom_entry = {T_DAT, 8'h55};
         4'd6:    rom_entry = {T_CMD, 8'h36};
         4'd7:    rom_entry = {T_DAT, 8'h48};
         4'd8:    rom_entry = {T_CMD, 8'h29};
         default: rom_entry = {T_END, 8'h00};
      endcase
   end

   assign rom_type = rom_entry[9:8];
   assign rom_byte = rom_entry[7:0];

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= 4'd0;
         cnt       <= '0;
         unit_cnt  <= '0;
         unit_num  <= 8'd0;
         unit_last <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tft_rst   <= 1'b1;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
         tx_dc     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_RST_LOW;
                  idx     <= 4'd0;
                  cnt     <= '0;
                  done    <= 1'b0;
                  busy    <= 1'b1;
                  tft_rst <= 1'b0;
               end
            end
            S_RST_LOW: begin
               if (cnt == LOW_LAST) begin
                  state   <= S_RST_WAIT;
                  cnt     <= '0;
                  tft_rst <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RST_WAIT: begin
               if (cnt == WAIT_LAST) begin
                  state <= S_FETCH;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_FETCH: begin
               case (rom_type)
                  T_CMD, T_DAT: begin
                     state    <= S_SEND;
                     tx_valid <= 1'b1;
                     tx_data  <= rom_byte;
                     tx_dc    <= (rom_type == T_DAT);
                  end
                  T_DLY: begin
                     if (rom_byte == 8'd0) begin
                        idx <= idx + 4'd1;
                     end else begin
                        state     <= S_DELAY;
                        unit_cnt  <= '0;
                        unit_num  <= 8'd0;
                        // Store N-1 so the unit compare needs no subtractor.
                        unit_last <= rom_byte - 8'd1;
                     end
                  end
                  default: begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               endcase
            end
            S_SEND: begin
               if (tx_ready) begin
                  state    <= S_FETCH;
                  tx_valid <= 1'b0;
                  idx      <= idx + 4'd1;
               end
            end
            S_DELAY: begin
               // Nested counters avoid forming N * DELAY_UNIT_CYC.
               if (unit_cnt == UNIT_LAST) begin
                  unit_cnt <= '0;
                  if (unit_num == unit_last) begin
                     state <= S_FETCH;
                     idx   <= idx + 4'd1;
                  end else begin
                     unit_num <= unit_num + 8'd1;
                  end
               end else begin
                  unit_cnt <= unit_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ili9341_init_seq.sv
module tb_ili9341_init_seq;

   localparam int RL = 4;
   localparam int RW = 8;
   localparam int DU = 2;
   localparam int BUDGET = 2000;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       tx_ready = 1'b0;
   logic       busy, done, tft_rst, tx_valid, tx_dc;
   logic [7:0] tx_data;

   ili9341_init_seq #(
      .RST_LOW_CYC   (RL),
      .RST_WAIT_CYC  (RW),
      .DELAY_UNIT_CYC(DU)
   ) dut (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .tft_rst (tft_rst),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_data (tx_data),
      .tx_dc   (tx_dc)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   int low_cnt = 0;
   logic [8:0] exp_q[$];
   int         hs_q[$];

   // {dc, byte} in the order the ROM should emit them
   logic [8:0] exp_seq [7] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every handshake pops one expected byte.
   always @(negedge sysclk) begin
      if (tft_rst === 1'b0) low_cnt++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         hs_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_extra actual=%0h required=none", {tx_dc, tx_data});
         end else begin
            chk("byte", {23'd0, tx_dc, tx_data}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic push_seq();
      foreach (exp_seq[i]) exp_q.push_back(exp_seq[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (done !== 1'b1 && k < BUDGET) begin
         tick(1);
         k++;
      end
      chk(name, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_byte(input logic [7:0] b);
      int k = 0;
      while (!(tx_valid === 1'b1 && tx_data === b) && k < BUDGET) begin
         tick(1);
         k++;
      end
      chk("see_byte", {24'd0, tx_data}, {24'd0, b});
   endtask

   initial begin
      // Reset values with random inputs while in reset
      rst_n = 1'b0;
      repeat (10) begin
         tx_ready = 1'($urandom_range(0, 1));
         start    = 1'($urandom_range(0, 1));
         tick(1);
         chk("reset_outs", {28'd0, tft_rst, tx_valid, busy, done}, 32'b1000);
      end
      start = 1'b0;
      tx_ready = 1'b0;
      rst_n = 1'b1;
      repeat (20) begin
         tick(1);
         chk("idle_outs", {28'd0, tft_rst, tx_valid, busy, done}, 32'b1000);
      end

      // Full run, tx_ready tied high
      tx_ready = 1'b1;
      hs_q.delete();
      low_cnt = 0;
      push_seq();
      pulse_start();
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_tft_low", {31'd0, tft_rst}, 32'd0);
      wait_done("run_done");
      chk("run_busy_end", {31'd0, busy}, 32'd0);
      chk("run_low_cycles", low_cnt, RL);
      chk("run_q_empty", exp_q.size(), 0);
      chk("run_hs_count", hs_q.size(), 7);
      if (hs_q.size() >= 3) begin
         chk("gap_dly5", hs_q[1] - hs_q[0], 5 * DU + 3);
         chk("gap_dly120", hs_q[2] - hs_q[1], 120 * DU + 3);
      end

      // Backpressure on 0x3A
      push_seq();
      pulse_start();
      wait_byte(8'h3A);
      tx_ready = 1'b0;
      repeat (7) begin
         tick(1);
         chk("bp_stable", {22'd0, tx_valid, tx_dc, tx_data}, {22'd0, 1'b1, 1'b0, 8'h3A});
      end
      tx_ready = 1'b1;
      wait_done("bp_done");
      chk("bp_q_empty", exp_q.size(), 0);

      // Start while busy inside the 120-unit delay
      hs_q.delete();
      low_cnt = 0;
      push_seq();
      pulse_start();
      begin
         int k = 0;
         while (hs_q.size() < 2 && k < BUDGET) begin
            tick(1);
            k++;
         end
      end
      chk("busy_hs2", hs_q.size(), 2);
      tick(50);
      pulse_start();
      chk("busy_tft_high", {31'd0, tft_rst}, 32'd1);
      chk("busy_still", {31'd0, busy}, 32'd1);
      wait_done("busy_done");
      chk("busy_low_cycles", low_cnt, RL);
      chk("busy_q_empty", exp_q.size(), 0);

      // Restart from DONE
      low_cnt = 0;
      push_seq();
      pulse_start();
      chk("restart_done_clr", {31'd0, done}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      wait_done("restart_done");
      chk("restart_low_cycles", low_cnt, RL);
      chk("restart_q_empty", exp_q.size(), 0);

      // Reset while 0x55 is presented
      push_seq();
      pulse_start();
      wait_byte(8'h55);
      tx_ready = 1'b0;
      chk("abort_q_left", exp_q.size(), 4);
      exp_q.delete();
      #2 rst_n = 1'b0;
      #1 chk("abort_outs", {28'd0, tft_rst, tx_valid, busy, done}, 32'b1000);
      tick(2);
      rst_n = 1'b1;
      tx_ready = 1'b1;
      tick(1);
      push_seq();
      pulse_start();
      wait_done("abort_rerun_done");
      chk("abort_q_empty", exp_q.size(), 0);

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
